// File: rtl/sram_vec_reader_if.sv
// rtl/sram_vec_reader_if.sv - SRAM port-A and output stream bundle for sram_vec_reader
interface sram_vec_reader_if #(
  parameter int BITS       = 32,
  parameter int ADDR_WIDTH = 13
);
  logic                  CEN;
  logic                  WEN;
  logic [ADDR_WIDTH-1:0] AA;
  logic [BITS-1:0]       DA;
  logic [BITS-1:0]       QA;
  logic                  out_valid;
  logic                  out_ready;
  logic [BITS-1:0]       out_data;
  logic                  out_last;

  modport master (
    output CEN, WEN, AA, DA, out_valid, out_data, out_last,
    input  QA, out_ready
  );

  modport slave (
    input  CEN, WEN, AA, DA, out_valid, out_data, out_last,
    output QA, out_ready
  );
endinterface

// File: rtl/sram_vec_reader.sv
// rtl/sram_vec_reader.sv - strided SRAM read engine with 3-entry skid FIFO; optional SRAM_RD_PERF_EN stall counter
module sram_vec_reader #(
  parameter int BITS       = 32,
  parameter int ADDR_WIDTH = 13,
  parameter int LEN_WIDTH  = 14
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic                  done,
  sram_vec_reader_if.master     bus
`ifdef SRAM_RD_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  remaining;
  logic                  inflight;
  logic                  inflight_last;
  logic [BITS-1:0]       fifo_data [3];
  logic [2:0]            fifo_last;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [1:0]            count;
  logic [2:0]            outstanding;
  logic                  issue;
  logic                  push;
  logic                  pop;
  logic                  valid;
  logic                  cmd_ok;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // issue decision uses only registered terms so out_ready never reaches CEN combinationally
  always_comb begin
    outstanding = {1'b0, count} + {2'b00, inflight};
    issue       = (state == ISSUE) && (remaining != '0) && (outstanding < 3'd3);
    push        = inflight;
    valid       = (count != 2'd0);
    pop         = valid && bus.out_ready;
    cmd_ok      = start && ((state == IDLE) || (state == DONE));
  end

  assign busy          = (state == ISSUE) || (state == DRAIN);
  assign done          = (state == DONE);
  assign bus.CEN       = !issue;
  assign bus.WEN       = 1'b1;
  assign bus.AA        = addr;
  assign bus.DA        = '0;
  assign bus.out_valid = valid;
  assign bus.out_data  = fifo_data[rd_ptr];
  assign bus.out_last  = valid && fifo_last[rd_ptr];

  // command FSM: latch the command, walk the strided addresses, wait for the last word to leave
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      addr      <= '0;
      stride_q  <= '0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            addr      <= base;
            stride_q  <= stride;
            remaining <= len;
            state     <= (len == '0) ? DONE : ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        ISSUE: begin
          if (issue) begin
            addr      <= addr + stride_q;
            remaining <= remaining - LEN_ONE;
            if (remaining == LEN_ONE) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && bus.out_last) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // read-latency tracking and skid FIFO; QA is captured only in the cycle after an issue
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= 2'd0;
      rd_ptr        <= 2'd0;
      count         <= 2'd0;
      fifo_last     <= 3'b000;
      for (int i = 0; i < 3; i++) fifo_data[i] <= '0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (remaining == LEN_ONE);
      if (push) begin
        fifo_data[wr_ptr] <= bus.QA;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ptr_next(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_next(rd_ptr);
      if (push && !pop)      count <= count + 2'd1;
      else if (!push && pop) count <= count - 2'd1;
    end
  end

`ifdef SRAM_RD_PERF_EN
  // saturating count of cycles where the consumer holds off a presented word; cleared per command
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_cycles <= '0;
    end else if (cmd_ok) begin
      stall_cycles <= '0;
    end else if (valid && !bus.out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_vec_reader.sv
// tb/tb_sram_vec_reader.sv - scoreboard bench for sram_vec_reader against a strided-read reference model
module tb_sram_vec_reader;
  localparam int BITS = 32;
  localparam int AW   = 13;
  localparam int LW   = 14;
  localparam int DEPTH = 1 << AW;

  logic          CLK = 1'b0;
  logic          RST_N;
  logic          start;
  logic [AW-1:0] base;
  logic [AW-1:0] stride;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
`ifdef SRAM_RD_PERF_EN
  logic [31:0]   stall_cycles;
`endif

  sram_vec_reader_if #(.BITS(BITS), .ADDR_WIDTH(AW)) bus ();

  sram_vec_reader #(.BITS(BITS), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .start        (start),
    .base         (base),
    .stride       (stride),
    .len          (len),
    .busy         (busy),
    .done         (done),
    .bus          (bus)
`ifdef SRAM_RD_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [BITS-1:0] data;
    logic            last;
  } word_t;

  logic [BITS-1:0] mem [0:DEPTH-1];
  word_t           exp_q[$];
  int              addr_q[$];
  int              done_cyc_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int issued = 0;
  int popped = 0;
  int first_cen = -1;
  int first_valid = -1;
  int tb_stall = 0;
  int bp_pct = 0;
  int lo_from = -1;
  int lo_to = -1;
  bit mon_en = 1'b0;
  bit prev_hold = 1'b0;
  logic [BITS-1:0] prev_data;
  logic            prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge CLK) cyc <= cyc + 1;

  // SRAM port-A model: one-cycle registered read, output holds when not enabled
  always @(posedge CLK) if (!bus.CEN) bus.QA <= mem[bus.AA];

  // consumer readiness: forced-low window or random backpressure
  always @(posedge CLK) begin
    #1;
    if (cyc >= lo_from && cyc <= lo_to) bus.out_ready = 1'b0;
    else bus.out_ready = ($urandom_range(99) >= bp_pct);
  end

  // monitor: compares every SRAM access and every accepted word against the scoreboard
  always @(negedge CLK) begin
    if (RST_N && mon_en) begin
      if (!bus.CEN) begin
        if (addr_q.size() == 0) chk("issue_without_request", {63'b0, bus.CEN}, 64'd1);
        else begin
          chk("addr", bus.AA, addr_q.pop_front());
          chk("wen", bus.WEN, 1);
          chk("da", bus.DA, 0);
        end
        issued++;
        if (first_cen < 0) first_cen = cyc;
      end
      if (issued - popped > 3) chk("outstanding_le3", issued - popped, 3);
      if (prev_hold) begin
        chk("valid_held", bus.out_valid, 1);
        chk("data_stable", bus.out_data, prev_data);
        chk("last_stable", bus.out_last, prev_last);
      end
      if (bus.out_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (exp_q.size() == 0) chk("valid_without_word", bus.out_valid, 0);
        else if (bus.out_ready) begin
          word_t w;
          w = exp_q.pop_front();
          chk("data", bus.out_data, w.data);
          chk("last", bus.out_last, w.last);
          popped++;
        end
        if (!bus.out_ready) tb_stall++;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_last = bus.out_last;
      if (done) done_cyc_q.push_back(cyc);
    end
  end

  task automatic wait_to(input int c);
    while (cyc < c) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic issue_cmd(input logic [AW-1:0] b, input logic [AW-1:0] s,
                           input logic [LW-1:0] l, output int t);
    int a;
    @(posedge CLK);
    #1;
    start = 1'b1;
    base = b;
    stride = s;
    len = l;
    t = cyc;
    first_cen = -1;
    first_valid = -1;
    tb_stall = 0;
    for (int i = 0; i < int'(l); i++) begin
      a = (int'(b) + i * int'(s)) % DEPTH;
      addr_q.push_back(a);
      exp_q.push_back('{data: mem[a], last: (i == int'(l) - 1)});
    end
    @(posedge CLK);
    #1;
    start = 1'b0;
    base = AW'($urandom);
    stride = AW'($urandom);
    len = LW'($urandom);
  endtask

  task automatic wait_done(output int dc);
    int k;
    k = 0;
    while (done_cyc_q.size() == 0 && k < 3000) begin
      @(negedge CLK);
      k++;
    end
    if (done_cyc_q.size() == 0) begin
      chk("done_timeout", 0, 1);
      dc = -1;
    end else begin
      dc = done_cyc_q.pop_front();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cen"}, bus.CEN, 1);
    chk({tag, "_wen"}, bus.WEN, 1);
    chk({tag, "_aa"}, bus.AA, 0);
    chk({tag, "_da"}, bus.DA, 0);
    chk({tag, "_valid"}, bus.out_valid, 0);
    chk({tag, "_last"}, bus.out_last, 0);
    chk({tag, "_data"}, bus.out_data, 0);
`ifdef SRAM_RD_PERF_EN
    chk({tag, "_stall"}, stall_cycles, 0);
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, t2, dc;
    logic [LW-1:0] rl;
    RST_N = 1'b0;
    start = 1'b0;
    base = '0;
    stride = '0;
    len = '0;
    bus.out_ready = 1'b1;
    bus.QA = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[10 + i] = 32'hA0A0_0000 + i;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check_idle_outputs("reset");
    RST_N = 1'b1;
    mon_en = 1'b1;

    // base 10, stride 1, len 4, then a command accepted in the DONE cycle that wraps the address space
    issue_cmd(13'd10, 13'd1, 14'd4, t);
    wait_to(t + 6);
    chk("t1_first_cen", first_cen, t + 1);
    chk("t1_first_valid", first_valid, t + 3);
    issue_cmd(13'd8190, 13'd3, 14'd3, t2);
    wait_done(dc);
    chk("t1_done_cycle", dc, t + 7);
    wait_done(dc);
    chk("t2_done_cycle", dc, t2 + 6);
    chk("t2_first_cen", first_cen, t2 + 1);
    chk("t2_words_left", exp_q.size(), 0);

    // len 0: immediate done, no SRAM access, no stream output
    issue_cmd(13'd77, 13'd2, 14'd0, t);
    wait_done(dc);
    chk("len0_done_cycle", dc, t + 1);
    repeat (5) @(negedge CLK);
    chk("len0_no_cen", first_cen, -1);
    chk("len0_no_valid", first_valid, -1);

    // len 6 with 5 cycles of backpressure from the first valid word
    issue_cmd(13'd1000, 13'd9, 14'd6, t);
    lo_from = t + 3;
    lo_to = t + 7;
    wait_done(dc);
    chk("bp_done_cycle", dc, t + 14);
    chk("bp_words_left", exp_q.size(), 0);
`ifdef SRAM_RD_PERF_EN
    chk("bp_stall_cycles", stall_cycles, 5);
`endif
    lo_from = -1;
    lo_to = -1;

    // second start while busy must be ignored
    issue_cmd(13'd100, 13'd5, 14'd8, t);
    wait_to(t + 4);
    chk("busy_mid", busy, 1);
    start = 1'b1;
    base = 13'd200;
    stride = 13'd1;
    len = 14'd2;
    @(posedge CLK);
    #1;
    start = 1'b0;
    wait_done(dc);
    chk("ignored_start_done_cycle", dc, t + 11);
    repeat (10) @(negedge CLK);
    chk("single_done", done_cyc_q.size(), 0);
    chk("ignored_start_no_extra_issue", addr_q.size(), 0);

    // one-cycle reset mid-stream, then a fresh command
    issue_cmd(13'd300, 13'd7, 14'd10, t);
    bp_pct = 40;
    wait_to(t + 6);
    mon_en = 1'b0;
    RST_N = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    check_idle_outputs("midreset");
    exp_q.delete();
    addr_q.delete();
    done_cyc_q.delete();
    issued = 0;
    popped = 0;
    prev_hold = 1'b0;
    RST_N = 1'b1;
    mon_en = 1'b1;
    bp_pct = 0;
    repeat (5) @(negedge CLK);
    chk("post_reset_no_valid", bus.out_valid, 0);
    issue_cmd(13'd500, 13'd1, 14'd5, t);
    wait_done(dc);
    chk("post_reset_done_cycle", dc, t + 8);
    chk("post_reset_words_left", exp_q.size(), 0);

    // randomized commands under random backpressure
    bp_pct = 35;
    for (int n = 0; n < 25; n++) begin
      rl = LW'($urandom_range(0, 12));
      if (n % 8 == 7) rl = 14'd40;
      issue_cmd(AW'($urandom), AW'($urandom), rl, t);
      wait_done(dc);
      chk("rand_words_left", exp_q.size(), 0);
      chk("rand_done_not_early", (dc >= t + int'(rl) + ((rl == 0) ? 1 : 3)), 1);
`ifdef SRAM_RD_PERF_EN
      chk("rand_stall_cycles", stall_cycles, tb_stall);
`endif
      repeat ($urandom_range(0, 3)) @(posedge CLK);
    end

    repeat (5) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sram_vec_reader.md
# sram_vec_reader

Streaming read engine for the dual-port vector SRAM. It sits on the SRAM's port A as initiator and drives CENA/WENA/AA/DA. It walks a strided address sequence and delivers the words to the solver datapath over a valid/ready stream with a last flag. A 3-entry skid FIFO absorbs the SRAM's one-cycle registered read latency, so full throughput is kept under arbitrary backpressure.

## Interface
- BITS, 32, data word width (equals SRAM BITS)
- ADDR_WIDTH, 13, SRAM address width
- LEN_WIDTH, 14, vector length width (max len 2^ADDR_WIDTH)
- CLK  in  1  clock, shared with SRAM
- RST_N  in  1  reset: one clock; reset is synchronous and active-low
- start  in  1  command strobe; accepted only when busy=0
- base  in  ADDR_WIDTH  first address
- stride  in  ADDR_WIDTH  address increment, modulo 2^ADDR_WIDTH
- len  in  LEN_WIDTH  number of words
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- CEN  out  1  SRAM port-A enable, active-low
- WEN  out  1  SRAM port-A write enable; constant 1 (read only)
- AA  out  ADDR_WIDTH  SRAM port-A address
- DA  out  BITS  SRAM port-A write data; constant 0
- QA  in  BITS  SRAM port-A read data
- out_valid  out  1  stream data valid
- out_ready  in  1  consumer ready
- out_data  out  BITS  stream data (FIFO head)
- out_last  out  1  head is the final word of the command
- stall_cycles  out  32  present only with SRAM_RD_PERF_EN

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, on start:
  - Latch base, stride, len.
  - len=0 → DONE; otherwise → ISSUE.
  - start while busy=1 is ignored.
- ISSUE:
  - Condition: remaining>0 and inflight+count<3 (register-only terms; no out_ready→CEN path).
  - When the condition holds: CEN=0, AA=current address; then addr+=stride (wraps), remaining−=1.
  - When the last word is issued → DRAIN.
- inflight:
  - Set the cycle after an issue; cleared otherwise.
  - When inflight=1, QA is pushed into the FIFO at the end of that cycle.
  - QA is ignored when inflight=0, because the SRAM holds stale data.
- Pop: out_valid&out_ready. Simultaneous push and pop in one cycle are legal; count is unchanged.
- out_valid=(count>0). out_last is set on the entry holding word len−1.
- DRAIN: once the last word pops → DONE.
- DONE: done=1 for one cycle, busy=0; → IDLE. start is accepted in the DONE cycle.
- busy=1 in ISSUE and DRAIN only.
- Reset values: busy=0, done=0, CEN=1, WEN=1, AA=0, DA=0, out_valid=0, out_last=0, out_data=0, FIFO empty, inflight=0, stall_cycles=0.
- Reset mid-command aborts the command. Any in-flight SRAM read is discarded; no stale out_valid after release.

## Timing
- start sampled in cycle t. First CEN=0 in t+1 (AA=base). QA valid in t+2, pushed at end of t+2. out_valid first in t+3.
- out_ready held 1: one word per cycle. len words occupy cycles t+3..t+len+2; done in t+len+3.
- len=0: done in t+1, CEN never low.
- Backpressure: at most 3 words outstanding (FIFO + in-flight). CEN stays 1 while inflight+count=3. No word is dropped or duplicated.
- out_data and out_last are stable while out_valid=1 and out_ready=0.

## Configuration
- SRAM_RD_PERF_EN defined:
  - 32-bit stall_cycles increments each cycle with out_valid=1 and out_ready=0.
  - It saturates at 2^32−1 and clears to 0 on an accepted start.
- Undefined: the stall_cycles port and counter are absent; all other behaviour is identical.

## Test plan
- mem[10..13]=A0..A3; start base=10 stride=1 len=4, out_ready=1 → CEN low t+1..t+4 with AA 10..13; data A0..A3 in t+3..t+6; out_last only on A3; done at t+7.
- base=8190 stride=3 len=3 → AA sequence 8190, 1, 4 (wrap); data matches mem at those addresses.
- len=0 → no CEN low cycle; done=1 at t+1; out_valid never asserted.
- len=6, out_ready low for 5 cycles from the first out_valid → CEN high while 3 outstanding; all 6 words in order with none lost; with SRAM_RD_PERF_EN, stall_cycles=5.
- Second start pulsed mid-command → ignored: no change to AA sequence, single done.
- RST_N low for 1 cycle mid-stream, then a new command → all outputs at reset values; new command returns only its own words.
